// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: state encodings and framing constants shared by the loader
package frame_loader_pkg;
    // State order follows the field order of a load record.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR_HI = 3'd1,
        S_ADDR_LO = 3'd2,
        S_COUNT   = 3'd3,
        S_DATA_HI = 3'd4,
        S_DATA_LO = 3'd5,
        S_CHECK   = 3'd6
    } state_t;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
endpackage

// File: rtl/frame_loader_timeout.sv
// byte_timeout: inter-byte idle counter; expired flags the last allowed idle cycle
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
    assign expired = en && (cnt_q == W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/frame_loader.sv
// frame_loader: parses framed load records from a byte stream and writes words to program memory
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0] HEADER_BYTE    = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [15:0] disp_word,
    output logic        busy,
    output logic        done,
    output logic        err
);
    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d, addr_q, addr_d, wdata_q, wdata_d, disp_q, disp_d;
    logic [7:0]  chk_q, chk_d, hi_q, hi_d, rem_q, rem_d;
    logic        we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        expired;

    byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid || state_q == S_IDLE),
        .en      (state_q != S_IDLE),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        disp_d  = disp_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        rem_d   = rem_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        // An arriving byte takes priority over a timeout expiring in the same cycle.
        if (rx_valid) begin
            chk_d = chk_q ^ rx_data;
            unique case (state_q)
                S_IDLE: begin
                    chk_d = '0;
                    if (rx_data == HEADER_BYTE) begin
                        err_d   = 1'b0;
                        state_d = S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    ptr_d   = {rx_data, ptr_q[7:0]};
                    state_d = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    ptr_d   = {ptr_q[15:8], rx_data};
                    state_d = S_COUNT;
                end
                S_COUNT: begin
                    rem_d   = rx_data;
                    state_d = rx_data == 8'd0 ? S_CHECK : S_DATA_HI;
                end
                S_DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = S_DATA_LO;
                end
                S_DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = {hi_q, rx_data};
                    disp_d  = {hi_q, rx_data};
                    ptr_d   = ptr_q + 16'd1;
                    rem_d   = rem_q - 8'd1;
                    state_d = rem_q == 8'd1 ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    chk_d   = chk_q;
                    done_d  = rx_data == chk_q;
                    err_d   = err_q | (rx_data != chk_q);
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expired) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
        end
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            disp_q  <= '0;
            chk_q   <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            disp_q  <= disp_d;
            chk_q   <= chk_d;
            hi_q    <= hi_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign disp_word = disp_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
